// File: rtl/risc16ba_io_bridge.sv
// risc16ba data-bus I/O responder at 0x0200-0x020F: LED registers, free-running timer, 8N1 UART TX.
// Define RISC16_IO_UART_EN to build the UART transmitter and its TX FIFO; otherwise uart_txd idles high.
module risc16ba_io_bridge #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 8,
  parameter int TMR_PRESCALE = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] daddr,
  input  logic [15:0] ddout,
  input  logic        doe,
  input  logic        dwe0,
  input  logic        dwe1,
  output logic        io_sel,
  output logic [15:0] io_ddin,
  output logic [23:0] led,
  output logic        uart_txd
);
  localparam int PW = (TMR_PRESCALE > 1) ? $clog2(TMR_PRESCALE) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(TMR_PRESCALE - 1);

  logic [2:0]    reg_idx;
  logic [7:0]    led0, led1, led2;
  logic [15:0]   tmr_cnt;
  logic [PW-1:0] tmr_div;
  logic [15:0]   status;
  logic          tmr_wr;
  logic          addr_unused;

  assign io_sel      = (daddr[15:4] == 12'h020);
  assign reg_idx     = daddr[3:1];
  assign addr_unused = daddr[0];
  assign tmr_wr      = io_sel && (reg_idx == 3'd2) && (dwe0 || dwe1);
  assign led         = {led2, led1, led0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led0 <= 8'h00;
      led1 <= 8'h00;
      led2 <= 8'h00;
    end else if (io_sel) begin
      if (reg_idx == 3'd0 && dwe1) led0 <= ddout[7:0];
      if (reg_idx == 3'd0 && dwe0) led1 <= ddout[15:8];
      if (reg_idx == 3'd1 && dwe1) led2 <= ddout[7:0];
    end
  end

  // Prescaler counts down; the timer steps when it hits zero. A write restarts both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_cnt <= 16'h0000;
      tmr_div <= DIV_LAST;
    end else if (tmr_wr) begin
      tmr_cnt <= 16'h0000;
      tmr_div <= DIV_LAST;
    end else if (tmr_div == '0) begin
      tmr_cnt <= tmr_cnt + 16'd1;
      tmr_div <= DIV_LAST;
    end else begin
      tmr_div <= tmr_div - 1'b1;
    end
  end

`ifdef RISC16_IO_UART_EN
  // state   | meaning
  // S_IDLE  | line high, waiting for FIFO data
  // S_START | start bit (0)
  // S_DATA  | 8 data bits, LSB first
  // S_STOP  | stop bit (1); chains straight into S_START when more data waits
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [AW:0]   FULL_CNT  = FIFO_DEPTH[AW:0];
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;
  tx_state_t state_q, state_d;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          fifo_empty, fifo_full, fifo_ovf;
  logic          txd_wr, stat_wr, push_ok, pop;
  logic [BW-1:0] baud_cnt;
  logic          bit_done;
  logic [2:0]    bit_idx;
  logic [7:0]    tx_shift;
  logic          txd_q;

  assign txd_wr     = io_sel && (reg_idx == 3'd3) && dwe1;
  assign stat_wr    = io_sel && (reg_idx == 3'd4) && dwe1;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign push_ok    = txd_wr && (!fifo_full || pop);
  assign bit_done   = (baud_cnt == '0);
  assign uart_txd   = txd_q;
  assign status     = {8'h00, 4'(fifo_cnt), fifo_ovf, fifo_full, fifo_empty, state_q != S_IDLE};

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= ddout[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE:  if (!fifo_empty) begin
                 pop     = 1'b1;
                 state_d = S_START;
               end
      S_START: if (bit_done) state_d = S_DATA;
      S_DATA:  if (bit_done && bit_idx == 3'd7) state_d = S_STOP;
      S_STOP:  if (bit_done) begin
                 if (!fifo_empty) begin
                   pop     = 1'b1;
                   state_d = S_START;
                 end else begin
                   state_d = S_IDLE;
                 end
               end
      default: state_d = S_IDLE;
    endcase
  end

  // txd is registered from the current state, so the line trails the FSM by one clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      fifo_ovf <= 1'b0;
      baud_cnt <= BAUD_LAST;
      bit_idx  <= 3'd0;
      tx_shift <= 8'h00;
      txd_q    <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!push_ok && pop) fifo_cnt <= fifo_cnt - 1'b1;
      if (txd_wr && fifo_full && !pop) fifo_ovf <= 1'b1;
      else if (stat_wr && ddout[3])    fifo_ovf <= 1'b0;
      if (pop || bit_done || state_q == S_IDLE) baud_cnt <= BAUD_LAST;
      else                                      baud_cnt <= baud_cnt - 1'b1;
      if (pop) begin
        tx_shift <= fifo_mem[rd_ptr];
        bit_idx  <= 3'd0;
      end else if (state_q == S_DATA && bit_done) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        bit_idx  <= bit_idx + 3'd1;
      end
      case (state_q)
        S_START: txd_q <= 1'b0;
        S_DATA:  txd_q <= tx_shift[0];
        default: txd_q <= 1'b1;
      endcase
    end
  end
`else
  assign uart_txd = 1'b1;
  assign status   = 16'h0002;
`endif

  always_comb begin
    io_ddin = 16'h0000;
    if (doe && io_sel) begin
      case (reg_idx)
        3'd0:    io_ddin = {led1, led0};
        3'd1:    io_ddin = {8'h00, led2};
        3'd2:    io_ddin = tmr_cnt;
        3'd4:    io_ddin = status;
        default: io_ddin = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_risc16ba_io_bridge.sv
// Randomized self-checking bench for risc16ba_io_bridge against a register/timer/UART-frame model.
// UART checks are compiled in when RISC16_IO_UART_EN is defined; otherwise the disabled-UART behaviour is checked.
module tb_risc16ba_io_bridge;
  localparam int CPB   = 4;
  localparam int PRE   = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] daddr = 16'h0000;
  logic [15:0] ddout = 16'h0000;
  logic        doe = 1'b0, dwe0 = 1'b0, dwe1 = 1'b0;
  logic        io_sel;
  logic [15:0] io_ddin;
  logic [23:0] led;
  logic        uart_txd;

  int n_checks = 0;
  int n_fail   = 0;

  risc16ba_io_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .TMR_PRESCALE(PRE)) dut (
    .clk(clk), .rst_n(rst_n), .daddr(daddr), .ddout(ddout), .doe(doe),
    .dwe0(dwe0), .dwe1(dwe1), .io_sel(io_sel), .io_ddin(io_ddin),
    .led(led), .uart_txd(uart_txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: LED bytes, and timer = clock edges since last clear / prescale.
  logic [7:0]  m_led0 = 8'h00, m_led1 = 8'h00, m_led2 = 8'h00;
  int unsigned tmr_edges = 0;
  int          cyc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmr_edges = 0;
    else if (daddr[15:4] == 12'h020 && daddr[3:1] == 3'd2 && (dwe0 || dwe1)) tmr_edges = 0;
    else tmr_edges++;
  end

  always @(posedge clk) cyc++;

  function automatic logic [15:0] exp_read(input logic [15:0] a);
    if (a[15:4] != 12'h020) return 16'h0000;
    case (a[3:1])
      3'd0:    return {m_led1, m_led0};
      3'd1:    return {8'h00, m_led2};
      3'd2:    return 16'((tmr_edges / PRE) % 65536);
      3'd4:    return 16'h0002;
      default: return 16'h0000;
    endcase
  endfunction

  // Serial line decoder: samples each bit in its middle, records bytes and start cycles.
  logic [7:0] rx_q[$];
  int         rx_start_q[$];
  int         bad_stop = 0;
  bit         rx_on = 1'b0;
  int         rx_pos = 0;
  logic [7:0] rx_byte = 8'h00;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) rx_on = 1'b0;
    else if (!rx_on) begin
      if (uart_txd == 1'b0) begin
        rx_on = 1'b1;
        rx_pos = 0;
        rx_start_q.push_back(cyc);
      end
    end else begin
      rx_pos++;
      if (rx_pos % CPB == CPB / 2) begin
        if (rx_pos / CPB >= 1 && rx_pos / CPB <= 8) rx_byte[rx_pos / CPB - 1] = uart_txd;
        else if (rx_pos / CPB == 9) begin
          if (uart_txd !== 1'b1) bad_stop++;
          rx_q.push_back(rx_byte);
          rx_on = 1'b0;
        end
      end
    end
  end

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic w0, input logic w1);
    daddr = a; ddout = d; dwe0 = w0; dwe1 = w1;
    @(negedge clk);
    dwe0 = 1'b0; dwe1 = 1'b0;
    if (a[15:4] == 12'h020) begin
      if (a[3:1] == 3'd0 && w1) m_led0 = d[7:0];
      if (a[3:1] == 3'd0 && w0) m_led1 = d[15:8];
      if (a[3:1] == 3'd1 && w1) m_led2 = d[7:0];
    end
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    daddr = a; doe = 1'b1;
    #1;
    d = io_ddin;
    doe = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic [15:0] s;
    int n = 0;
    rd(16'h0208, s);
    while (s != 16'h0002 && n < 1000) begin
      @(negedge clk);
      rd(16'h0208, s);
      n++;
    end
    check(tag, s, 16'h0002);
    repeat (2 * CPB) @(negedge clk);
  endtask

  initial begin
    logic [15:0] d, a;
    logic [63:0] obs, expv;
    logic [7:0]  tx_b [6];
    logic [7:0]  exp_q[$];
    int          n, seg, low_seen;
    bit          seen;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_led", led, 24'h0);
    check("rst_txd", uart_txd, 1);
    rd(16'h0208, d); check("rst_status", d, 16'h0002);
    repeat (20) @(negedge clk);
    rd(16'h0204, d); check("tmr_20", d, 16'h000A);
    check("tmr_model", d, exp_read(16'h0204));

    wr(16'h0200, 16'hA55A, 1'b1, 1'b1);
    wr(16'h0202, 16'h1234, 1'b1, 1'b1);
    check("led_wr", led, 24'h34A55A);
    rd(16'h0200, d); check("rd_led01", d, 16'hA55A);
    rd(16'h0202, d); check("rd_led2", d, 16'h0034);
    @(negedge clk);
    wr(16'h0201, 16'hFF00, 1'b1, 1'b0);
    check("led_lane_hi", led, 24'h34FF5A);
    wr(16'h0205, 16'h0000, 1'b0, 1'b1);
    rd(16'h0204, d); check("tmr_clear", d, 16'h0000);
    @(negedge clk);

    force dut.tmr_cnt = 16'hFFFF;
    #1;
    release dut.tmr_cnt;
    rd(16'h0204, d); check("tmr_preload", d, 16'hFFFF);
    seen = 1'b0;
    for (int i = 0; i < 2 * PRE + 2 && !seen; i++) begin
      @(negedge clk);
      rd(16'h0204, d);
      if (d != 16'hFFFF) seen = 1'b1;
    end
    check("tmr_wrap", d, 16'h0000);
    @(negedge clk);
    wr(16'h0204, 16'h0000, 1'b1, 1'b0);

`ifdef RISC16_IO_UART_EN
    rx_q.delete(); rx_start_q.delete();
    wr(16'h0206, 16'h0055, 1'b0, 1'b1);
    @(negedge clk);
    check("pop_latency", uart_txd, 1);
    daddr = 16'h0208; doe = 1'b1;
    obs = '0; expv = '0; d = 16'h0000;
    for (int j = 0; j < 10 * CPB; j++) begin
      seg = j / CPB;
      expv[j] = (seg == 0) ? 1'b0 : (seg <= 8) ? (((8'h55 >> (seg - 1)) & 8'h01) != 0) : 1'b1;
    end
    for (int j = 0; j < 10 * CPB + 4; j++) begin
      @(negedge clk);
      if (j < 10 * CPB) obs[j] = uart_txd;
      if (j == 5 * CPB) d = io_ddin;
    end
    check("frame_55", obs, expv);
    check("busy_mid", d, 16'h0003);
    check("status_after", io_ddin, 16'h0002);
    doe = 1'b0;
    check("rx_55", (rx_q.size() == 1) ? rx_q[0] : 8'hxx, 8'h55);

    rx_q.delete(); rx_start_q.delete();
    for (int k = 0; k < 6; k++) tx_b[k] = 8'($urandom);
    for (int k = 0; k < 6; k++) wr(16'h0206, {8'h00, tx_b[k]}, 1'b0, 1'b1);
    rd(16'h0208, d); check("ovf_full", d, 16'h004D);
    @(negedge clk);
    wr(16'h0208, 16'h00F7, 1'b0, 1'b1);
    rd(16'h0208, d); check("ovf_keep", d, 16'h004D);
    @(negedge clk);
    wr(16'h0208, 16'h0008, 1'b0, 1'b1);
    rd(16'h0208, d); check("ovf_clear", d, 16'h0045);
    wait_idle("burst_idle");
    check("burst_count", rx_q.size(), 5);
    for (int k = 0; k < 5 && k < rx_q.size(); k++) check("burst_byte", rx_q[k], tx_b[k]);
    for (int k = 0; k + 1 < rx_start_q.size(); k++)
      check("burst_gap", rx_start_q[k + 1] - rx_start_q[k], 10 * CPB);
    check("stop_bits", bad_stop, 0);

    for (int r = 0; r < 3; r++) begin
      rx_q.delete(); rx_start_q.delete(); exp_q.delete();
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        exp_q.push_back(8'($urandom));
        wr(16'h0206, {8'($urandom), exp_q[k]}, 1'b0, 1'b1);
      end
      wait_idle("rand_idle");
      check("rand_count", rx_q.size(), n);
      for (int k = 0; k < n && k < rx_q.size(); k++) check("rand_byte", rx_q[k], exp_q[k]);
    end

    wr(16'h0200, 16'hFFFF, 1'b1, 1'b1);
    wr(16'h0206, 16'h0055, 1'b0, 1'b1);
    wr(16'h0206, 16'h00A3, 1'b0, 1'b1);
    wr(16'h0206, 16'h003C, 1'b0, 1'b1);
    repeat (17) @(negedge clk);
    check("pre_rst_txd", uart_txd, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_txd", uart_txd, 1);
    check("rst_async_led", led, 24'h0);
    m_led0 = 8'h00; m_led1 = 8'h00; m_led2 = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    rd(16'h0208, d); check("rst_status2", d, 16'h0002);
    low_seen = 0;
    repeat (12 * CPB) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) low_seen++;
    end
    check("fifo_lost", low_seen, 0);
`else
    wr(16'h0206, 16'h0055, 1'b0, 1'b1);
    low_seen = 0;
    repeat (12 * CPB) begin
      @(negedge clk);
      if (uart_txd !== 1'b1) low_seen++;
    end
    check("txd_tied", low_seen, 0);
    rd(16'h0208, d); check("status_off", d, 16'h0002);
    rd(16'h0206, d); check("txdata_rd", d, 16'h0000);
    @(negedge clk);
    wr(16'h0200, 16'hFFFF, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_led", led, 24'h0);
    m_led0 = 8'h00; m_led1 = 8'h00; m_led2 = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
`endif

    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      a = 16'h0200 | 16'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        if (a[3:1] == 3'd3) a = a ^ 16'h0002;
        wr(a, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("rand_led", led, {m_led2, m_led1, m_led0});
      end else begin
        rd(a, d);
        check("rand_rd", d, exp_read(a));
        check("rand_sel", io_sel, 1);
        @(negedge clk);
      end
    end

    rd(16'h0210, d); check("rd_outside_hi", d, 16'h0000);
    check("sel_outside_hi", io_sel, 0);
    rd(16'h01FE, d); check("rd_outside_lo", d, 16'h0000);
    check("sel_outside_lo", io_sel, 0);
    daddr = 16'h0200; doe = 1'b0;
    #1 check("rd_no_doe", io_ddin, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
